btn_step_ctrl: RTL and testbench

Conditions the two raw push-buttons of the sequence-stepping datapath. Produces a direction level and single-cycle step pulses for the downstream sequence FSM, which advances one position per step.
- Covers synchronisation, debounce, press-edge detection and auto-repeat while a button is held.
- Rejects simultaneous two-button presses.

---
 rtl/step_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 72 +++++++
 rtl/btn_step_ctrl.sv | 139 +++++++++++++
 tb/tb_btn_step_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// -----------------------------------------------------------------------------
// step_pkg
// Shared types and constants for the push-button step controller.
//   state_e        : step FSM states
//   DEF_*          : default timing parameters (in clk cycles)
//   DIR_UP/DIR_DN  : encoding of the 'up' direction output
//   BTN_UP/BTN_DN  : index of each button in the per-button vectors
//   max2()         : elaboration-time helper for parameter arithmetic
// -----------------------------------------------------------------------------
package step_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2,
    LOCK        = 2'd3
  } state_e;

  localparam int DEF_DB_CYCLES    = 500_000;
  localparam int DEF_REPEAT_DELAY = 25_000_000;
  localparam int DEF_REPEAT_RATE  = 5_000_000;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int BTN_UP = 0;
  localparam int BTN_DN = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One raw active-low button -> synchronised, debounced pressed level plus
// single-cycle press/release events.
//   clk, rst      : clock, asynchronous active-high reset
//   raw_n         : raw button, active-low, asynchronous to clk
//   level         : debounced pressed level (1 = pressed)
//   press         : one cycle high after level rises
//   release_pulse : one cycle high after level falls ('release' is a reserved
//                   word, hence the longer name)
// -----------------------------------------------------------------------------
module btn_debounce
  import step_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic          level_prev_q, level_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // Inversion happens before the synchroniser so reset means "released".
    meta_d       = ~raw_n;
    sync_d       = meta_q;
    level_prev_d = level_q;
    level_d      = level_q;
    cnt_d        = '0;
    if (sync_q != level_q) begin
      // The counter only runs while the input disagrees with the level, so any
      // agreement (a glitch ending) throws away the accumulated count.
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
    end
  end

  assign level         = level_q;
  assign press         = level_q & ~level_prev_q;
  assign release_pulse = ~level_q & level_prev_q;

endmodule

// File: rtl/btn_step_ctrl.sv
// -----------------------------------------------------------------------------
// btn_step_ctrl
// Turns the up/down push-buttons into step pulses plus a direction level for
// the sequence FSM, with hold-to-repeat and two-button lockout.
//   clk, rst  : clock, asynchronous active-high reset
//   btn_up_n  : raw up button, active-low, asynchronous
//   btn_dn_n  : raw down button, active-low, asynchronous
//   step      : one-cycle pulse, advance the sequence one position
//   up        : direction (1 = up), updated only on the first step of a press
//   locked    : high while both buttons are involved (LOCK state)
// -----------------------------------------------------------------------------
module btn_step_ctrl
  import step_pkg::*;
#(
  parameter int DB_CYCLES    = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_n,
  input  logic btn_dn_n,
  output logic step,
  output logic up,
  output logic locked
);

  // Intervals below 2 would let step stay high on back-to-back cycles.
  localparam int DELAY_EFF = max2(REPEAT_DELAY, 2);
  localparam int RATE_EFF  = max2(REPEAT_RATE, 2);
  localparam int TW        = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [TW-1:0] DELAY_LOAD = TW'(DELAY_EFF - 1);
  localparam logic [TW-1:0] RATE_LOAD  = TW'(RATE_EFF - 1);

  logic [1:0] raw_n;
  logic [1:0] lvl;
  logic [1:0] prs;
  logic [1:0] rel;

  assign raw_n[BTN_UP] = btn_up_n;
  assign raw_n[BTN_DN] = btn_dn_n;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .raw_n        (raw_n[gi]),
        .level        (lvl[gi]),
        .press        (prs[gi]),
        .release_pulse(rel[gi])
      );
    end
  endgenerate

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          step_q, step_d;
  logic          up_q, up_d;

  logic other_lvl;
  logic held_rel;

  // While holding, up_q identifies which button started the hold.
  assign other_lvl = (up_q == DIR_UP) ? lvl[BTN_DN] : lvl[BTN_UP];
  assign held_rel  = (up_q == DIR_UP) ? rel[BTN_UP] : rel[BTN_DN];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = 1'b0;
    up_d    = up_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (prs[BTN_UP] && prs[BTN_DN]) begin
          state_d = LOCK;
        end else if (prs[BTN_UP] || prs[BTN_DN]) begin
          // A press while the other button is already down involves both.
          if ((prs[BTN_UP] && lvl[BTN_DN]) || (prs[BTN_DN] && lvl[BTN_UP])) begin
            state_d = LOCK;
          end else begin
            step_d  = 1'b1;
            up_d    = prs[BTN_UP] ? DIR_UP : DIR_DN;
            timer_d = DELAY_LOAD;
            state_d = HOLD_DELAY;
          end
        end
      end
      HOLD_DELAY, HOLD_REPEAT: begin
        // Lockout beats release, and both beat a coincident timer expiry.
        if (other_lvl) begin
          state_d = LOCK;
          timer_d = '0;
        end else if (held_rel) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          step_d  = 1'b1;
          timer_d = RATE_LOAD;
          state_d = HOLD_REPEAT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      LOCK: begin
        timer_d = '0;
        if (!lvl[BTN_UP] && !lvl[BTN_DN]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      step_q  <= 1'b0;
      up_q    <= DIR_UP;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      step_q  <= step_d;
      up_q    <= up_d;
    end
  end

  assign step   = step_q;
  assign up     = up_q;
  assign locked = (state_q == LOCK);

endmodule

// File: tb/tb_btn_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_step_ctrl
// Directed stimulus for btn_step_ctrl with DB_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=8. Stimulus pushes expected steps (cycle, direction) into a
// queue; a monitor on the falling edge pops and compares every step pulse.
// Cycle numbering: cyc equals the index of the most recent rising edge.
// -----------------------------------------------------------------------------
module tb_btn_step_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_up_n = 1'b1;
  logic btn_dn_n = 1'b1;
  logic step;
  logic up;
  logic locked;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int   at;
    logic dir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_step_ctrl #(
    .DB_CYCLES   (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_up_n(btn_up_n),
    .btn_dn_n(btn_dn_n),
    .step    (step),
    .up      (up),
    .locked  (locked)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_step(input int at, input logic dir);
    exp_t e;
    e.at  = at;
    e.dir = dir;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d expected steps missing (first due cycle %0d), required 0",
               name, exp_q.size(), exp_q[0].at);
      exp_q.delete();
    end
  endtask

  // Monitor: every step pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      $display("step cycle=%0d up=%0b", cyc, up);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_step: got step at cycle %0d up=%0b, required no step", cyc, up);
      end else begin
        mon_e = exp_q.pop_front();
        check("step_cycle", cyc, mon_e.at);
        check("step_dir", 32'(up), 32'(mon_e.dir));
      end
    end
  end

  initial begin
    int n;
    int r;
    rst = 1'b1;
    wait_cyc(3);
    check("rst_step", 32'(step), 32'd0);
    check("rst_up", 32'(up), 32'd1);
    check("rst_locked", 32'(locked), 32'd0);
    rst = 1'b0;

    // 1. Idle for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      wait_cyc(1);
      if (i % 10 == 9) begin
        check("idle_up", 32'(up), 32'd1);
        check("idle_locked", 32'(locked), 32'd0);
      end
    end

    // 2. Short glitch, then a short dn press: one step.
    btn_dn_n = 1'b0;
    wait_cyc(DB - 1);
    btn_dn_n = 1'b1;
    wait_cyc(15);
    check_drained("glitch");
    n = cyc;
    btn_dn_n = 1'b0;
    expect_step(n + DB + 3, 1'b0);
    wait_cyc(10);
    btn_dn_n = 1'b1;
    wait_cyc(20);
    check("dn_dir_held", 32'(up), 32'd0);
    check_drained("dn_single");

    // 3. Up held 60 cycles: first step, delayed repeat, then rate repeats.
    n = cyc;
    btn_up_n = 1'b0;
    expect_step(n + 7, 1'b1);
    for (int k = 0; k < 5; k++) expect_step(n + 7 + RD + k * RR, 1'b1);
    wait_cyc(60);
    btn_up_n = 1'b1;
    wait_cyc(20);
    check_drained("up_repeat");
    check("up_repeat_locked", 32'(locked), 32'd0);

    // 4. Both pressed together -> LOCK until both released.
    n = cyc;
    btn_up_n = 1'b0;
    btn_dn_n = 1'b0;
    wait_cyc(6);
    check("lock_before", 32'(locked), 32'd0);
    wait_cyc(1);
    check("lock_enter", 32'(locked), 32'd1);
    btn_up_n = 1'b1;
    wait_cyc(15);
    check("lock_one_released", 32'(locked), 32'd1);
    btn_dn_n = 1'b1;
    wait_cyc(6);
    check("lock_exit_before", 32'(locked), 32'd1);
    wait_cyc(1);
    check("lock_exit", 32'(locked), 32'd0);
    check("lock_up_kept", 32'(up), 32'd1);
    wait_cyc(5);
    check_drained("lock_both");

    // 5. dn pressed during repeat; LOCK beats the coincident repeat expiry.
    n = cyc;
    btn_up_n = 1'b0;
    expect_step(n + 7, 1'b1);
    expect_step(n + 27, 1'b1);
    expect_step(n + 35, 1'b1);
    wait_cyc(36);
    btn_dn_n = 1'b0;
    wait_cyc(6);
    check("repeat_lock_before", 32'(locked), 32'd0);
    wait_cyc(1);
    check("repeat_lock_enter", 32'(locked), 32'd1);
    wait_cyc(20);
    check("repeat_lock_held", 32'(locked), 32'd1);
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    wait_cyc(10);
    check("repeat_lock_exit", 32'(locked), 32'd0);
    check_drained("repeat_lock");
    n = cyc;
    btn_dn_n = 1'b0;
    expect_step(n + 7, 1'b0);
    wait_cyc(10);
    check("dn_after_lock_dir", 32'(up), 32'd0);
    // Asynchronous reset mid-cycle while holding dn.
    #1 rst = 1'b1;
    #1;
    check("async_rst_up", 32'(up), 32'd1);
    check("async_rst_step", 32'(step), 32'd0);
    check("async_rst_locked", 32'(locked), 32'd0);
    btn_dn_n = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(10);
    check_drained("dn_after_lock");

    // Asynchronous reset out of LOCK.
    btn_up_n = 1'b0;
    btn_dn_n = 1'b0;
    wait_cyc(10);
    check("async_lock_pre", 32'(locked), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_lock", 32'(locked), 32'd0);
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(10);
    check("async_lock_post", 32'(locked), 32'd0);
    check_drained("async_lock");

    // 6. Reset while up held: fresh press after reset release.
    n = cyc;
    btn_up_n = 1'b0;
    expect_step(n + 7, 1'b1);
    wait_cyc(15);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    r = cyc;
    expect_step(r + DB + 3, 1'b1);
    expect_step(r + DB + 3 + RD, 1'b1);
    wait_cyc(28);
    btn_up_n = 1'b1;
    wait_cyc(20);
    check_drained("rst_mid_press");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
